spi_sclk_gen: RTL and testbench
===============================

SPI_SCLK_GEN -- requirements
Module: spi_sclk_gen

Interface
REQ-001 Parameter DIV_W, 16, width of half-period divider input.
REQ-002 Parameter CNT_W, 6, width of bits-per-transfer input.
REQ-003 Port clk  in  1  system clock; all logic rising-edge.
REQ-004 Port reset  in  1  asynchronous, active-high reset.
REQ-005 Port div_i  in  DIV_W  SCLK half-period in clk cycles; sampled at start only.
REQ-006 Port cpol_i  in  1  SCLK idle level; sampled at start, tracked in IDLE.
REQ-007 Port cpha_i  in  1  clock phase; sampled at start.
REQ-008 Port nbits_i  in  CNT_W  bits per transfer; sampled at start.
REQ-009 Port start_i  in  1  transfer request, level-sampled.
REQ-010 Port abort_i  in  1  terminate transfer.
REQ-011 Port sclk_o  out  1  registered SPI clock.
REQ-012 Port sample_o  out  1  one-cycle strobe, MISO sampling edge.
REQ-013 Port shift_o  out  1  one-cycle strobe, MOSI launch edge.
REQ-014 Port busy_o  out  1  high while in RUN or GUARD.
REQ-015 Port done_o  out  1  one-cycle pulse at normal completion.

Function
REQ-016 FSM states IDLE, RUN, GUARD; all outputs registered.
REQ-017 IDLE: start_i=1 and nbits_i!=0 at cycle T latches div (0 treated as 1), cpol, cpha, nbits -> RUN at T+1; start with nbits_i=0 ignored.
REQ-018 RUN: half-period counter 0..div-1, cleared on RUN entry; terminal count toggles sclk_o, visible at T+1+div, then every div cycles.
REQ-019 Edge count 2*nbits; odd edges leading, even trailing; after edge 2*nbits -> GUARD.
REQ-020 CPHA=0: sample_o on leading edges, shift_o on trailing edges except the final one.
REQ-021 CPHA=1: shift_o on leading edges, sample_o on trailing edges.
REQ-022 Strobes asserted in the same cycle the new sclk_o value first appears; never both high.
REQ-023 GUARD: sclk_o held at latched cpol for div cycles, then IDLE with done_o=1 for that one cycle, busy_o=0 same cycle.
REQ-024 Total start-to-done: 1 + 2*nbits*div + div cycles.
REQ-025 IDLE: sclk_o follows cpol_i with one-cycle latency.
REQ-026 start_i while busy ignored; div_i/cpol_i/cpha_i/nbits_i changes mid-transfer ignored.
REQ-027 abort_i in RUN/GUARD: next cycle IDLE, sclk_o=latched cpol, no strobes, no done_o; abort_i has priority over terminal count; abort_i in IDLE has no effect.
REQ-028 Counter wrap: div=2^DIV_W-1 supported without overflow; div=1 gives SCLK=clk/2.

Reset
REQ-029 reset: state IDLE, counters 0, sclk_o=0, sample_o=shift_o=busy_o=done_o=0.
REQ-030 reset mid-transfer: immediate return to reset values; no done_o.

Configuration
REQ-031 Macro SPI_SCLK_GEN_STALL_EN defined: extra port stall_i (in, 1); stall_i=1 in RUN/GUARD freezes counter, no edges/strobes; abort_i overrides.
REQ-032 Macro undefined: no stall_i port; behaviour identical to stall_i=0.

Structure
REQ-033 Package spi_pkg: state enum typedef, {cpol,cpha} mode typedef, default DIV_W/CNT_W constants.
REQ-034 Sub-module spi_halfperiod_timer: load/clear, enable, terminal-count strobe; instantiated once.

Verification
REQ-035 Mode 0, div=3, nbits=8, start at T -> first sclk_o rise T+4, 16 edges, 8 sample_o on rises, 7 shift_o, done_o at T+52.
REQ-036 Mode 3 (cpol=1,cpha=1), div=1, nbits=2 -> sclk_o idles 1, 4 edges 1 cycle apart, shift_o on falls, sample_o on rises, done_o at T+6.
REQ-037 div=0, nbits=1 -> behaves as div=1; nbits=0 start -> busy_o stays 0.
REQ-038 abort_i after edge 5, div=4 -> next cycle IDLE, sclk_o=cpol, no done_o; new start accepted the following cycle.
REQ-039 reset asserted mid-RUN -> all outputs 0 asynchronously; start_i during busy ignored (edge count unchanged).
REQ-040 With SPI_SCLK_GEN_STALL_EN, stall_i high 10 cycles mid-RUN, div=2, nbits=4 -> done_o delayed exactly 10 cycles.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and default widths for the SPI serial-clock generator.
package spi_pkg;

    localparam int SPI_DIV_W_DEF = 16;
    localparam int SPI_CNT_W_DEF = 6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_GUARD = 2'd2
    } spi_state_t;

    typedef struct packed {
        logic cpol;
        logic cpha;
    } spi_mode_t;

endpackage

// File: rtl/spi_halfperiod_timer.sv
// Half-period timer: counts 0..term_i while enabled and strobes tc_o on the
// last count. clear has priority and returns the count to zero.
module spi_halfperiod_timer
    import spi_pkg::*;
#(
    parameter int DIV_W = SPI_DIV_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    input  logic [DIV_W-1:0] term_i,
    output logic             tc_o
);

    localparam logic [DIV_W-1:0] CNT_ONE = DIV_W'(1);

    logic [DIV_W-1:0] cnt;

    // term_i is div-1, so the counter never needs to exceed 2^DIV_W-2.
    assign tc_o = enable && (cnt == term_i);

    // Count while enabled, wrap to zero on terminal count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clear || tc_o) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= cnt + CNT_ONE;
        end
    end

endmodule

// File: rtl/spi_sclk_gen.sv
// SPI serial-clock generator: produces SCLK for all four CPOL/CPHA modes plus
// MISO-sample and MOSI-shift strobes aligned with the SCLK edges.
// Optional feature: define SPI_SCLK_GEN_STALL_EN to add a stall_i input that
// freezes the half-period timer while a transfer is active.
module spi_sclk_gen
    import spi_pkg::*;
#(
    parameter int DIV_W = SPI_DIV_W_DEF,
    parameter int CNT_W = SPI_CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [DIV_W-1:0] div_i,
    input  logic             cpol_i,
    input  logic             cpha_i,
    input  logic [CNT_W-1:0] nbits_i,
    input  logic             start_i,
    input  logic             abort_i,
`ifdef SPI_SCLK_GEN_STALL_EN
    input  logic             stall_i,
`endif
    output logic             sclk_o,
    output logic             sample_o,
    output logic             shift_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
    localparam logic [CNT_W:0]   EDGE_ONE = (CNT_W + 1)'(1);

    spi_state_t       state;
    spi_mode_t        mode_l;
    logic [DIV_W-1:0] term_l;
    logic [CNT_W-1:0] nbits_l;
    logic [CNT_W:0]   edge_cnt;
    logic [CNT_W:0]   edge_next;
    logic             stall;
    logic             active;
    logic             tc;
    logic             leading;
    logic             last_edge;

`ifdef SPI_SCLK_GEN_STALL_EN
    assign stall = stall_i;
`else
    assign stall = 1'b0;
`endif

    assign active    = (state != ST_IDLE);
    assign edge_next = edge_cnt + EDGE_ONE;
    // Odd edge numbers are the leading edges of a bit.
    assign leading   = edge_next[0];
    assign last_edge = (edge_next == {nbits_l, 1'b0});

    spi_halfperiod_timer #(
        .DIV_W (DIV_W)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (!active || abort_i),
        .enable (active && !stall),
        .term_i (term_l),
        .tc_o   (tc)
    );

    // Transfer FSM; every output is registered so strobes line up with SCLK.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            mode_l   <= '0;
            term_l   <= '0;
            nbits_l  <= '0;
            edge_cnt <= '0;
            sclk_o   <= 1'b0;
            sample_o <= 1'b0;
            shift_o  <= 1'b0;
            busy_o   <= 1'b0;
            done_o   <= 1'b0;
        end else begin
            sample_o <= 1'b0;
            shift_o  <= 1'b0;
            done_o   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    sclk_o <= cpol_i;
                    if (start_i && (nbits_i != '0)) begin
                        mode_l   <= {cpol_i, cpha_i};
                        // A divider of 0 behaves like 1.
                        term_l   <= (div_i == '0) ? '0 : (div_i - DIV_ONE);
                        nbits_l  <= nbits_i;
                        edge_cnt <= '0;
                        busy_o   <= 1'b1;
                        state    <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (abort_i) begin
                        sclk_o <= mode_l.cpol;
                        busy_o <= 1'b0;
                        state  <= ST_IDLE;
                    end else if (tc) begin
                        sclk_o   <= ~sclk_o;
                        edge_cnt <= edge_next;
                        if (mode_l.cpha) begin
                            shift_o  <= leading;
                            sample_o <= !leading;
                        end else begin
                            sample_o <= leading;
                            // No launch after the final trailing edge.
                            shift_o  <= !leading && !last_edge;
                        end
                        if (last_edge) begin
                            state <= ST_GUARD;
                        end
                    end
                end
                ST_GUARD: begin
                    if (abort_i) begin
                        sclk_o <= mode_l.cpol;
                        busy_o <= 1'b0;
                        state  <= ST_IDLE;
                    end else if (tc) begin
                        sclk_o <= mode_l.cpol;
                        busy_o <= 1'b0;
                        done_o <= 1'b1;
                        state  <= ST_IDLE;
                    end
                end
                default: begin
                    busy_o <= 1'b0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_sclk_gen.sv
// Self-checking bench for spi_sclk_gen: table of directed transfers, a few
// hand-written corner sequences, then randomized transfers against an
// arithmetic reference model of the SCLK/strobe timeline.
module tb_spi_sclk_gen;

    localparam int DIV_W = 16;
    localparam int CNT_W = 6;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [DIV_W-1:0] div_i = '0;
    logic             cpol_i = 1'b0;
    logic             cpha_i = 1'b0;
    logic [CNT_W-1:0] nbits_i = '0;
    logic             start_i = 1'b0;
    logic             abort_i = 1'b0;
`ifdef SPI_SCLK_GEN_STALL_EN
    logic             stall_i = 1'b0;
`endif
    logic             sclk_o;
    logic             sample_o;
    logic             shift_o;
    logic             busy_o;
    logic             done_o;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int div;
        int nbits;
        bit cpol;
        bit cpha;
        int abort_at;
        bit noise;
        int exp_len;
        int exp_samp;
        int exp_shift;
    } vec_t;

    vec_t vecs [9];

    spi_sclk_gen #(
        .DIV_W (DIV_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .div_i    (div_i),
        .cpol_i   (cpol_i),
        .cpha_i   (cpha_i),
        .nbits_i  (nbits_i),
        .start_i  (start_i),
        .abort_i  (abort_i),
`ifdef SPI_SCLK_GEN_STALL_EN
        .stall_i  (stall_i),
`endif
        .sclk_o   (sclk_o),
        .sample_o (sample_o),
        .shift_o  (shift_o),
        .busy_o   (busy_o),
        .done_o   (done_o)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    // Expected {sclk, sample, shift, busy, done} at cycle offset i after the
    // start request was sampled (offset 1 is the first RUN cycle).
    function automatic logic [4:0] model(int div, int nbits, bit cpol, bit cpha, int i);
        int d;
        int last;
        int k;
        bit is_new;
        bit lead;
        bit samp;
        bit shf;
        d = (div == 0) ? 1 : div;
        last = 1 + 2 * nbits * d + d;
        samp = 1'b0;
        shf = 1'b0;
        if (i >= last) return {cpol, 4'b0001};
        k = (i - 1) / d;
        if (k > 2 * nbits) k = 2 * nbits;
        is_new = ((i - 1) % d == 0) && ((i - 1) / d >= 1) && ((i - 1) / d <= 2 * nbits);
        if (is_new) begin
            lead = (k % 2) == 1;
            if (cpha) begin
                shf = lead;
                samp = !lead;
            end else begin
                samp = lead;
                shf = !lead && (k != 2 * nbits);
            end
        end
        return {cpol ^ k[0], samp, shf, 1'b1, 1'b0};
    endfunction

    // Called just after a falling edge. Requests a transfer, then checks every
    // cycle until done (or the cycle after an abort).
    task automatic run_xfer(input string tag, input int div, input int nbits, input bit cpol,
                            input bit cpha, input int abort_at, input bit noise,
                            output int done_off, output int n_samp, output int n_shift);
        int d;
        int last;
        int stop;
        logic [4:0] got;
        logic [4:0] want;
        d = (div == 0) ? 1 : div;
        last = 1 + 2 * nbits * d + d;
        stop = (abort_at != 0) ? abort_at + 1 : last;
        done_off = 0;
        n_samp = 0;
        n_shift = 0;
        div_i = DIV_W'(div);
        nbits_i = CNT_W'(nbits);
        cpol_i = cpol;
        cpha_i = cpha;
        abort_i = 1'b0;
        start_i = 1'b1;
        for (int i = 1; i <= stop; i++) begin
            @(negedge clk);
            got = {sclk_o, sample_o, shift_o, busy_o, done_o};
            if (abort_at != 0 && i == abort_at + 1)
                want = {cpol, 4'b0000};
            else
                want = model(div, nbits, cpol, cpha, i);
            check($sformatf("%s_off%0d", tag, i), 32'(got), 32'(want));
            if (sample_o) n_samp++;
            if (shift_o) n_shift++;
            if (done_o && done_off == 0) done_off = i;
            if (i == stop) begin
                start_i = 1'b0;
                abort_i = 1'b0;
                cpol_i = cpol;
            end else begin
                abort_i = (abort_at != 0) && (i == abort_at);
                if (noise) begin
                    div_i = DIV_W'($urandom);
                    nbits_i = CNT_W'($urandom);
                    cpol_i = 1'($urandom);
                    cpha_i = 1'($urandom);
                    start_i = 1'($urandom);
                end else begin
                    start_i = 1'b0;
                end
            end
        end
    endtask

    // Idle cycles: sclk follows cpol_i one cycle later, nothing else moves.
    task automatic idle_follow(input string tag, input int cycles, input bit zero_start);
        logic prev;
        for (int c = 0; c < cycles; c++) begin
            cpol_i = 1'($urandom);
            abort_i = 1'($urandom);
            start_i = zero_start;
            if (zero_start) begin
                nbits_i = '0;
                div_i = DIV_W'($urandom_range(0, 4));
            end
            prev = cpol_i;
            @(negedge clk);
            check($sformatf("%s_sclk%0d", tag, c), 32'(sclk_o), 32'(prev));
            check($sformatf("%s_quiet%0d", tag, c),
                  32'({sample_o, shift_o, busy_o, done_o}), 32'(0));
        end
        start_i = 1'b0;
        abort_i = 1'b0;
    endtask

    initial begin
        int done_off;
        int n_samp;
        int n_shift;
        int div;
        int nbits;
        int d;
        int last;
        int ab;
        bit cpol;
        bit cpha;

        //            div nb cpol cpha abort noise len samp shift
        vecs[0] = '{3,   8,  0, 0,  0, 0,  52, 8,  7};
        vecs[1] = '{1,   2,  1, 1,  0, 0,   6, 2,  2};
        vecs[2] = '{0,   1,  0, 0,  0, 0,   4, 1,  0};
        vecs[3] = '{4,   4,  0, 0, 21, 0,   0, 3,  2};
        vecs[4] = '{2,   3,  0, 1,  0, 1,  15, 3,  3};
        vecs[5] = '{5,   2,  1, 0,  0, 1,  26, 2,  1};
        vecs[6] = '{255, 1,  0, 0,  0, 0, 766, 1,  0};
        vecs[7] = '{1,  63,  1, 1,  0, 1, 128, 63, 63};
        vecs[8] = '{3,   1,  0, 0,  8, 0,   0, 1,  0};

        #1;
        check("reset_outputs", 32'({sclk_o, sample_o, shift_o, busy_o, done_o}), 32'(0));
        @(negedge clk);
        reset = 1'b0;
        idle_follow("idle0", 4, 1'b0);

        for (int v = 0; v < 9; v++) begin
            run_xfer($sformatf("vec%0d", v), vecs[v].div, vecs[v].nbits, vecs[v].cpol,
                     vecs[v].cpha, vecs[v].abort_at, vecs[v].noise, done_off, n_samp, n_shift);
            check($sformatf("vec%0d_done_off", v), 32'(done_off), 32'(vecs[v].exp_len));
            check($sformatf("vec%0d_samples", v), 32'(n_samp), 32'(vecs[v].exp_samp));
            check($sformatf("vec%0d_shifts", v), 32'(n_shift), 32'(vecs[v].exp_shift));
            if (vecs[v].abort_at == 0) idle_follow($sformatf("vec%0d_idle", v), 3, 1'b0);
        end

        // Start with nbits=0 is ignored.
        idle_follow("nbits0", 5, 1'b1);

        // Asynchronous reset in the middle of a transfer.
        cpol_i = 1'b1;
        cpha_i = 1'b0;
        div_i = 16'd2;
        nbits_i = 6'd4;
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        repeat (4) @(negedge clk);
        check("pre_reset_busy", 32'(busy_o), 32'(1));
        check("pre_reset_sclk", 32'(sclk_o), 32'(1));
        #2 reset = 1'b1;
        #1 check("async_reset", 32'({sclk_o, sample_o, shift_o, busy_o, done_o}), 32'(0));
        @(negedge clk);
        reset = 1'b0;
        idle_follow("post_reset", 20, 1'b0);

`ifdef SPI_SCLK_GEN_STALL_EN
        begin
            int seen;
            seen = 0;
            cpol_i = 1'b0;
            cpha_i = 1'b0;
            div_i = 16'd2;
            nbits_i = 6'd4;
            start_i = 1'b1;
            for (int i = 1; i <= 200 && seen == 0; i++) begin
                @(negedge clk);
                start_i = 1'b0;
                stall_i = (i >= 4) && (i < 14);
                if (done_o) seen = i;
            end
            stall_i = 1'b0;
            check("stall_done_off", 32'(seen), 32'(29));
            idle_follow("stall_idle", 2, 1'b0);
        end
`endif

        for (int r = 0; r < 12; r++) begin
            div = $urandom_range(0, 5);
            nbits = $urandom_range(1, 8);
            cpol = 1'($urandom);
            cpha = 1'($urandom);
            d = (div == 0) ? 1 : div;
            last = 1 + 2 * nbits * d + d;
            ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, last - 1) : 0;
            run_xfer($sformatf("rnd%0d", r), div, nbits, cpol, cpha, ab, 1'b1,
                     done_off, n_samp, n_shift);
            if (ab == 0) idle_follow($sformatf("rnd%0d_idle", r), 2, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
